serial_bit_source: RTL and testbench
====================================

Name: serial_bit_source

Overview:
- Parallel-to-serial stage that sits directly upstream of the single-bit serial consumer (inputs clk, rst_n, a).
- Accepts WIDTH-bit words over a valid/ready handshake.
- Drives them out one bit per advance cycle on out_bit, which wires straight to the consumer's 1-bit serial input.
- Marks each frame's final bit with out_last and paces shifting with an external tick strobe.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- MSB_FIRST, 0, 0 = shift LSB first, 1 = shift MSB first.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a valid word.
- din_ready  output  1  block accepts din this cycle; transfer occurs when din_valid && din_ready at a rising edge.
- tick  input  1  advance strobe; the output bit changes only on edges where tick=1.
- out_bit  output  1  current serial bit; feeds consumer input a.
- out_valid  output  1  out_bit carries frame data.
- out_last  output  1  out_bit is the final bit of the frame.
- busy  output  1  a frame is in progress (state != IDLE).

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; shift register, bit counter, out_bit, out_valid, out_last and busy all cleared to 0.
  - Reset overrides any transfer in the same cycle.
  - A reset mid-frame aborts the frame; the remaining bits are discarded.
- States:
  - IDLE: no frame in progress.
  - SHIFT: data bits being output.
  - PAR: parity bit being output; exists only with PARITY_EN.
- din_ready (combinational from registered state and tick):
  - 1 in IDLE.
  - 1 in the final output slot when tick=1: SHIFT on its last bit without PARITY_EN, or PAR with PARITY_EN.
  - 0 otherwise.
  - din_ready must not depend on din_valid.
- Accept:
  - On an accepting edge, din is loaded.
  - The first bit (din[0], or din[WIDTH-1] if MSB_FIRST) appears on out_bit registered, in the cycle after the edge.
  - In that cycle out_valid=1, busy=1, state=SHIFT, and the counter is set to WIDTH-1.
  - Latency from accept to first bit is 1 cycle, independent of tick.
- Advance:
  - In SHIFT, on an edge with tick=1 the next bit is presented and the counter decrements.
  - With tick=0 all outputs hold.
  - Each bit is therefore held for at least 1 cycle, and until the next tick.
- out_last = 1 while the final slot is presented: the last data bit, or the parity bit with PARITY_EN.
- Frame end:
  - On a tick edge in the final slot with no accept, go to IDLE; out_valid, out_last and busy drop to 0 and out_bit to 0.
  - On a tick edge in the final slot with an accept, load the new word and present its first bit the next cycle. The stream has no gap bit (back-to-back frames).
- din_valid while din_ready=0 is ignored; the word is not captured and the upstream must hold it.
- No downstream backpressure; the consumer samples out_bit every cycle out_valid=1 and tick qualifies the advance.
- The counter width is clog2(WIDTH) bits; there is no wrap, since the counter reaching 0 defines the last bit.
- out_bit, out_valid, out_last and busy are all registered outputs.

Optional Feature:
- Macro: SERIAL_BIT_SOURCE_PARITY_EN.
- Defined:
  - After the last data bit, the next tick enters PAR and drives an even-parity bit, equal to the XOR of all WIDTH data bits.
  - out_last moves from the last data bit to the parity bit.
  - The frame is WIDTH+1 slots.
- Undefined:
  - The PAR state and parity logic are absent.
  - The frame is WIDTH slots, with out_last on the last data bit.

Test Plan:
- Reset, then idle:
  - Hold rst_n=0 for 3 cycles, release with din_valid=0 -> all outputs 0, din_ready=1, busy=0 for 10 cycles.
- Single LSB-first frame:
  - WIDTH=8, MSB_FIRST=0, tick=1, send 8'hA5 -> out_bit sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after accept.
  - out_last=1 only on the 8th bit; then IDLE.
- Back-to-back frames:
  - din_valid held with 8'h0F then 8'hF0, tick=1 -> 16 contiguous valid bits 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1.
  - din_ready=1 exactly on each last-bit cycle; out_valid never drops between frames.
- Tick pacing and MSB_FIRST:
  - MSB_FIRST=1, send 8'h80, tick=1 every 4th cycle -> first bit 1, held until the first tick edge, then seven 0 bits each held 4 cycles.
  - din_valid asserted mid-frame is not accepted.
- Reset mid-frame:
  - Assert rst_n=0 after the 3rd bit of 8'hFF -> next cycle all outputs 0, state IDLE.
  - The next word 8'h01 serializes cleanly: 1 followed by seven 0s.
- Parity (macro defined):
  - Send 8'h07 -> 9 slots: 1,1,1,0,0,0,0,0, then parity 1.
  - out_last only on the parity slot; 8'h03 gives parity 0.

Source files
------------

// File: rtl/serial_bit_source_if.sv
// Word-in / bit-out bundle for serial_bit_source: upstream valid/ready word port,
// the tick pacing strobe and the registered serial outputs.
interface serial_bit_source_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             tick;
  logic             out_bit;
  logic             out_valid;
  logic             out_last;
  logic             busy;

  modport master (
    output din, din_valid, tick,
    input  din_ready, out_bit, out_valid, out_last, busy
  );

  modport slave (
    input  din, din_valid, tick,
    output din_ready, out_bit, out_valid, out_last, busy
  );
endinterface

// File: rtl/serial_bit_source.sv
// Parallel-to-serial source: WIDTH-bit words in, one bit per tick out, frame end on out_last.
// Optional trailing even-parity slot when SERIAL_BIT_SOURCE_PARITY_EN is defined.
module serial_bit_source #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_bit_source_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
  localparam logic [1:0] PAR   = 2'd2;
`endif

  logic [1:0]       state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    cnt_q;
  logic             out_bit_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic             busy_q;
  logic             final_slot;
  logic             accept;
  logic             advance;

`ifdef SERIAL_BIT_SOURCE_PARITY_EN
  logic par_q;
  assign final_slot = (state_q == PAR);
`else
  assign final_slot = (state_q == SHIFT) && (cnt_q == '0);
`endif

  // Ready only from registered state and tick, so a new word chains onto the final slot.
  assign bus.din_ready = (state_q == IDLE) || (final_slot && bus.tick);
  assign accept        = bus.din_valid && bus.din_ready;
  assign advance       = bus.tick && (state_q != IDLE);

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] drop_first(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else if (accept) begin
      // shreg_q keeps only the bits not yet presented
      state_q     <= SHIFT;
      shreg_q     <= drop_first(bus.din);
      cnt_q       <= CW'(WIDTH - 1);
      out_bit_q   <= first_bit(bus.din);
      out_valid_q <= 1'b1;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b1;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
      par_q       <= ^bus.din;
`endif
    end else if (advance) begin
      if ((state_q == SHIFT) && (cnt_q != '0)) begin
        shreg_q   <= drop_first(shreg_q);
        cnt_q     <= cnt_q - 1'b1;
        out_bit_q <= first_bit(shreg_q);
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
        out_last_q <= 1'b0;
`else
        out_last_q <= (cnt_q == CW'(1));
`endif
      end
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
      else if (state_q == SHIFT) begin
        state_q    <= PAR;
        out_bit_q  <= par_q;
        out_last_q <= 1'b1;
      end
`endif
      else begin
        state_q     <= IDLE;
        out_bit_q   <= 1'b0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        busy_q      <= 1'b0;
      end
    end
  end

  assign bus.out_bit   = out_bit_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_serial_bit_source.sv
// Bench for serial_bit_source: LSB-first and MSB-first instances share one stimulus,
// each with a slot scoreboard checked against every output on every cycle.
module tb_serial_bit_source;
`ifdef SERIAL_BIT_SOURCE_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic b;
    logic l;
  } slot_t;

  typedef struct {
    logic [7:0] word;
    int         period;
    logic       exp_par;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       tick = 1'b0;
  logic       exp_par = 1'b0;
  int         tick_period = 1;
  int         tcnt = 0;
  int         checks = 0;
  int         errors = 0;
  bit         do_final = 1'b0;
  logic       rdy [2];
  logic       ov  [2];
  vec_t       vec [6];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    tick = (tick_period <= 1) || ((tcnt % tick_period) == 0);
    tcnt++;
  end

  task automatic chk(input string nm, input int d, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t got %b expected %b", nm, d, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    serial_bit_source_if #(.WIDTH(8)) bus ();

    assign bus.din       = din;
    assign bus.din_valid = din_valid;
    assign bus.tick      = tick;
    assign rdy[g]        = bus.din_ready;
    assign ov[g]         = bus.out_valid;

    serial_bit_source #(.WIDTH(8), .MSB_FIRST(g)) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );

    slot_t q[$];
    logic  cur_v = 1'b0, cur_b = 1'b0, cur_l = 1'b0;
    bit    pend_rst = 1'b0, pend_adv = 1'b0, live = 1'b0, fin_done = 1'b0;

    always @(negedge clk) begin : mon
      slot_t s;
      logic  exp_rdy;
      if (pend_rst) begin
        q.delete();
        cur_v = 1'b0; cur_b = 1'b0; cur_l = 1'b0;
        live  = 1'b1;
      end else if (pend_adv) begin
        if (q.size() > 0) begin
          s = q.pop_front();
          cur_v = 1'b1; cur_b = s.b; cur_l = s.l;
        end else begin
          cur_v = 1'b0; cur_b = 1'b0; cur_l = 1'b0;
        end
      end
      exp_rdy = !cur_v || (cur_l && tick);
      if (live) begin
        chk("out_valid", g, bus.out_valid, cur_v);
        chk("out_bit",   g, bus.out_bit,   cur_b);
        chk("out_last",  g, bus.out_last,  cur_l);
        chk("busy",      g, bus.busy,      cur_v);
        chk("din_ready", g, bus.din_ready, exp_rdy);
      end
      pend_rst = !rst_n;
      pend_adv = rst_n && ((din_valid && exp_rdy) || (tick && cur_v));
      if (rst_n && din_valid && exp_rdy) begin
        for (int i = 0; i < 8; i++)
          q.push_back('{b: ((g != 0) ? din[7-i] : din[i]), l: (i == 7) && !PAR_EN});
        if (PAR_EN) q.push_back('{b: exp_par, l: 1'b1});
      end
      if (do_final && !fin_done) begin
        fin_done = 1'b1;
        chk("queue_drained", g, (q.size() == 0), 1'b1);
      end
    end
  end

  task automatic send(input logic [7:0] w, input logic p);
    int n;
    din = w; exp_par = p; din_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy[0] && n < 300);
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL send_timeout word=%h got no din_ready required din_ready=1", w);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((ov[0] || ov[1]) && n < 500);
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL idle_timeout got out_valid=1 required out_valid=0");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    vec[0] = '{word: 8'hA5, period: 1, exp_par: 1'b0};
    vec[1] = '{word: 8'h07, period: 1, exp_par: 1'b1};
    vec[2] = '{word: 8'h03, period: 1, exp_par: 1'b0};
    vec[3] = '{word: 8'h80, period: 4, exp_par: 1'b1};
    vec[4] = '{word: 8'hFF, period: 2, exp_par: 1'b0};
    vec[5] = '{word: 8'h01, period: 3, exp_par: 1'b1};

    // reset held three edges, then idle with nothing offered
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      tick_period = vec[i].period;
      send(vec[i].word, vec[i].exp_par);
      din_valid = 1'b0;
      wait_idle();
    end

    // back-to-back frames with din_valid held
    tick_period = 1;
    send(8'h0F, 1'b0);
    send(8'hF0, 1'b0);
    din_valid = 1'b0;
    wait_idle();

    // slow tick; second word offered mid-frame must wait for the final slot
    tick_period = 4;
    send(8'h80, 1'b1);
    send(8'h55, 1'b0);
    din_valid = 1'b0;
    wait_idle();

    // reset while the third bit is on the line, then a clean frame
    tick_period = 1;
    send(8'hFF, 1'b0);
    din_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8'h01, 1'b1);
    din_valid = 1'b0;
    wait_idle();

    do_final = 1'b1;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
